// File: rtl/counter_req_sched.sv
// counter_req_sched: round-robin arbiter feeding one shared up/down counter, with a bounds-checking shadow and clear sequencing
module counter_req_sched #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_VAL  = 15,
   parameter int INIT_VAL = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_dec,
   input  logic [2*NUM_REQ-1:0]   req_amt,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic                   clr_req,
   output logic                   clr_ack,
   output logic                   cnt_incr_valid,
   output logic [1:0]             cnt_incr,
   output logic                   cnt_decr_valid,
   output logic [1:0]             cnt_decr,
   output logic                   cnt_reinit,
   input  logic [3:0]             cnt_value,
   output logic [3:0]             shadow,
   output logic                   err
);
   localparam int         PW   = $clog2(NUM_REQ);
   localparam logic [3:0] INIT = 4'(INIT_VAL);
   localparam logic [4:0] MAXV = 5'(MAX_VAL);
   typedef enum logic {RUN, CLR} state_t;
   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d, win;
   logic [3:0]        shadow_q, shadow_d, shadow_d1_q, shadow_d1_d;
   logic [NUM_REQ-1:0] elig, gnt;
   logic              found, win_dec, legal, go, run;
   logic [1:0]        win_amt, incr_q, incr_d, decr_q, decr_d;
   logic              incr_v_q, incr_v_d, decr_v_q, decr_v_d, err_q, err_d;
   function automatic logic ok(input logic v, input logic d, input logic [1:0] a, input logic [3:0] s);
      return v & ((a == 2'd0 || a == 2'd3) || (d ? s >= {2'b0, a} : {1'b0, s} + {3'b0, a} <= MAXV));
   endfunction
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++)
         elig[i] = ok(req_valid[i], req_dec[i], req_amt[2*i +: 2], shadow_q);
   end
   // Two passes: from the pointer upward first, then wrap around to the low indices.
   always_comb begin
      gnt = '0;
      win = '0;
      win_amt = '0;
      win_dec = 1'b0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (!found && i >= int'(ptr_q) && elig[i]) begin
            found = 1'b1;
            win = PW'(i);
            gnt[i] = 1'b1;
            win_amt = req_amt[2*i +: 2];
            win_dec = req_dec[i];
         end
      for (int i = 0; i < NUM_REQ; i++)
         if (!found && elig[i]) begin
            found = 1'b1;
            win = PW'(i);
            gnt[i] = 1'b1;
            win_amt = req_amt[2*i +: 2];
            win_dec = req_dec[i];
         end
   end
   assign run       = state_q == RUN && !clr_req && !rst;
   assign go        = run && found;
   assign legal     = win_amt == 2'd1 || win_amt == 2'd2;
   assign req_ready = run ? gnt : '0;
   // The counter reloads one cycle before the shadow delay line would, so the
   // delayed copy is forced to INIT during CLR to keep the cross-check aligned.
   always_comb begin
      state_d     = (state_q == RUN && clr_req) ? CLR : RUN;
      ptr_d       = go ? ((int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1) : ptr_q;
      shadow_d    = state_q == CLR ? INIT :
                    (go && legal) ? (win_dec ? shadow_q - {2'b0, win_amt} : shadow_q + {2'b0, win_amt}) :
                    shadow_q;
      incr_v_d    = go && legal && !win_dec;
      decr_v_d    = go && legal && win_dec;
      incr_d      = incr_v_d ? win_amt : '0;
      decr_d      = decr_v_d ? win_amt : '0;
      shadow_d1_d = state_q == CLR ? INIT : shadow_q;
      err_d       = err_q | (cnt_value != shadow_d1_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         ptr_q       <= '0;
         shadow_q    <= INIT;
         shadow_d1_q <= INIT;
         incr_v_q    <= 1'b0;
         decr_v_q    <= 1'b0;
         incr_q      <= '0;
         decr_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         shadow_q    <= shadow_d;
         shadow_d1_q <= shadow_d1_d;
         incr_v_q    <= incr_v_d;
         decr_v_q    <= decr_v_d;
         incr_q      <= incr_d;
         decr_q      <= decr_d;
         err_q       <= err_d;
      end
   end
   assign cnt_reinit     = state_q == CLR;
   assign clr_ack        = state_q == CLR;
   assign cnt_incr_valid = incr_v_q;
   assign cnt_incr       = incr_q;
   assign cnt_decr_valid = decr_v_q;
   assign cnt_decr       = decr_q;
   assign shadow         = shadow_q;
   assign err            = err_q;
endmodule

// File: tb/tb_counter_req_sched.sv
// tb_counter_req_sched: directed bench with a behavioural scheduler model and an attached counter model
module tb_counter_req_sched;
   localparam int N = 4, MAXV = 15, INIT = 0;
   logic           clk = 1'b0, rst = 1'b1;
   logic [N-1:0]   req_valid = '0, req_dec = '0, req_ready;
   logic [2*N-1:0] req_amt = '0;
   logic           clr_req = 1'b0, clr_ack, civ, cdv, crein, err;
   logic [1:0]     ci, cd;
   logic [3:0]     cnt_value, shadow, cnt = 4'(INIT), inject = '0;
   int             n_cmp = 0, n_bad = 0;
   int             m_shadow = INIT, m_ptr = 0, m_inc = 0, m_dec = 0;
   bit             m_clr = 1'b0, m_err = 1'b0;
   counter_req_sched #(.NUM_REQ(N), .MAX_VAL(MAXV), .INIT_VAL(INIT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_dec(req_dec), .req_amt(req_amt),
      .req_ready(req_ready), .clr_req(clr_req), .clr_ack(clr_ack),
      .cnt_incr_valid(civ), .cnt_incr(ci), .cnt_decr_valid(cdv), .cnt_decr(cd),
      .cnt_reinit(crein), .cnt_value(cnt_value), .shadow(shadow), .err(err)
   );
   always #5 clk = ~clk;
   // The shared counter, plus an injectable offset on what it reports.
   assign cnt_value = cnt + inject;
   always @(posedge clk)
      if (rst || crein) cnt <= 4'(INIT);
      else if (civ) cnt <= cnt + 4'(ci);
      else if (cdv) cnt <= cnt - 4'(cd);
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int amt_of(input int i);
      return int'(req_amt[2*i +: 2]);
   endfunction
   function automatic int model_grant();
      if (rst || m_clr || clr_req) return -1;
      for (int k = 0; k < N; k++) begin
         int i, a;
         i = (m_ptr + k) % N;
         a = amt_of(i);
         if (req_valid[i] && (a == 0 || a == 3 || (req_dec[i] ? m_shadow >= a : m_shadow + a <= MAXV)))
            return i;
      end
      return -1;
   endfunction
   task automatic model_step();
      int w, a;
      w = model_grant();
      if (rst) begin
         m_shadow = INIT; m_ptr = 0; m_clr = 0; m_inc = 0; m_dec = 0; m_err = 0;
      end else begin
         m_err = m_err || inject != 0;
         m_inc = 0;
         m_dec = 0;
         if (m_clr) begin
            m_clr = 0;
            m_shadow = INIT;
         end else if (clr_req) m_clr = 1;
         else if (w >= 0) begin
            a = amt_of(w);
            if (a == 1 || a == 2) begin
               if (req_dec[w]) begin m_shadow -= a; m_dec = a; end
               else begin m_shadow += a; m_inc = a; end
            end
            m_ptr = (w + 1) % N;
         end
      end
   endtask
   initial forever begin
      @(posedge clk);
      model_step();
   end
   initial forever begin
      int w;
      @(negedge clk);
      if (!rst) begin
         w = model_grant();
         chk("m_ready", int'(req_ready), w < 0 ? 0 : (1 << w));
         chk("m_incr_valid", int'(civ), int'(m_inc != 0));
         chk("m_incr", int'(ci), m_inc);
         chk("m_decr_valid", int'(cdv), int'(m_dec != 0));
         chk("m_decr", int'(cd), m_dec);
         chk("m_reinit", int'(crein), int'(m_clr));
         chk("m_clr_ack", int'(clr_ack), int'(m_clr));
         chk("m_shadow", int'(shadow), m_shadow);
         chk("m_err", int'(err), int'(m_err));
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic setreq(input int i, input bit v, input bit d, input int a);
      req_valid[i] = v;
      req_dec[i] = d;
      req_amt[2*i +: 2] = 2'(a);
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_shadow", int'(shadow), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_cmd", int'({civ, cdv, crein, clr_ack}), 0);
      // single increment and its latency
      step(); setreq(0, 1, 0, 2);
      @(negedge clk); chk("t1_ready", int'(req_ready), 1);
      step(); setreq(0, 0, 0, 0);
      @(negedge clk); chk("t1_incr_v", int'(civ), 1); chk("t1_incr", int'(ci), 2); chk("t1_shadow", int'(shadow), 2);
      step();
      @(negedge clk); chk("t1_cnt", int'(cnt_value), 2); chk("t1_idle", int'(civ), 0); chk("t1_err", int'(err), 0);
      // four requesters back to back from a fresh pointer
      step(); rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      for (int i = 0; i < N; i++) setreq(i, 1, 0, 1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); chk("t2_ready", int'(req_ready), 1 << (k % 4));
         step();
      end
      req_valid = '0; req_amt = '0;
      @(negedge clk); chk("t2_shadow", int'(shadow), 8);
      // saturation skip
      step(); setreq(0, 1, 0, 2);
      repeat (3) step();
      setreq(0, 0, 0, 0); setreq(1, 1, 0, 2); setreq(2, 1, 1, 1);
      @(negedge clk); chk("t3_shadow14", int'(shadow), 14); chk("t3_skip", int'(req_ready), 4);
      step(); setreq(2, 0, 0, 0);
      @(negedge clk); chk("t3_shadow13", int'(shadow), 13); chk("t3_ready1", int'(req_ready), 2);
      step(); setreq(1, 0, 0, 0);
      @(negedge clk); chk("t3_shadow15", int'(shadow), 15);
      // underflow stall
      step(); setreq(0, 1, 1, 2);
      repeat (7) step();
      @(negedge clk); chk("t4_shadow1", int'(shadow), 1);
      repeat (3) begin
         @(negedge clk); chk("t4_stall", int'(req_ready), 0);
         step();
      end
      setreq(3, 1, 0, 1);
      @(negedge clk); chk("t4_ready3", int'(req_ready), 8);
      step(); setreq(3, 0, 0, 0);
      @(negedge clk); chk("t4_ready0", int'(req_ready), 1); chk("t4_shadow2", int'(shadow), 2);
      step(); setreq(0, 0, 0, 0);
      @(negedge clk); chk("t4_shadow0", int'(shadow), 0);
      // clear sequencing with requests pending
      step(); setreq(0, 1, 0, 1);
      repeat (9) step();
      for (int i = 0; i < N; i++) setreq(i, 1, 0, 1);
      clr_req = 1'b1;
      @(negedge clk); chk("t5_idle", int'(req_ready), 0); chk("t5_shadow9", int'(shadow), 9); chk("t5_no_reinit", int'(crein), 0);
      step();
      @(negedge clk); chk("t5_reinit", int'(crein), 1); chk("t5_ack", int'(clr_ack), 1); chk("t5_hold", int'(req_ready), 0);
      step(); clr_req = 1'b0;
      @(negedge clk); chk("t5_shadow0", int'(shadow), 0); chk("t5_resume", int'(req_ready), 2); chk("t5_ack_off", int'(clr_ack), 0);
      step(); req_valid = '0; req_amt = '0;
      @(negedge clk); chk("t5_shadow1", int'(shadow), 1);
      step();
      @(negedge clk); chk("t5_err", int'(err), 0);
      // illegal amount and error injection
      step(); setreq(2, 1, 0, 3);
      @(negedge clk); chk("t6_ready", int'(req_ready), 4);
      step(); setreq(2, 0, 0, 0);
      @(negedge clk); chk("t6_no_cmd", int'({civ, cdv}), 0); chk("t6_shadow", int'(shadow), 1);
      step(); inject = 4'd1;
      @(negedge clk); chk("t6_err_pre", int'(err), 0);
      step(); inject = 4'd0;
      @(negedge clk); chk("t6_err_set", int'(err), 1);
      repeat (3) step();
      @(negedge clk); chk("t6_err_sticky", int'(err), 1);
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      @(negedge clk); chk("t6_err_rst", int'(err), 0); chk("t6_shadow_rst", int'(shadow), 0);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
